// File: rtl/abl17_cla_adder_pipe_chk.sv
// Two-stage pipelined carry-lookahead adder built from 4-bit CLA groups.
// Stage 1 adds the low half and predicts the mod-3 residue of the result.
// Stage 2 adds the high half from the registered mid carry and checks the residue.
// A selectable group carry can be inverted to exercise the residue checker.
module abl17_cla_adder_pipe_chk #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 8,
   localparam int unsigned NG    = WIDTH / 4,
   localparam int unsigned SEL_W = $clog2(NG)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             fault_en,
   input  logic [SEL_W-1:0] fault_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             chk_err,
   output logic             err_flag,
   output logic [CNT_W-1:0] err_count,
   input  logic             err_clear
);

   localparam int unsigned HW = WIDTH / 2;
   localparam int unsigned HG = NG / 2;

   // Group generate/propagate of a 4-bit slice, returned as {G, P}
   function automatic logic [1:0] cla4_gp(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] g;
      logic [3:0] p;
      g = x & y;
      p = x ^ y;
      return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
   endfunction

   // 4-bit sum with in-group lookahead carries
   function automatic logic [3:0] cla4_sum(input logic [3:0] x, input logic [3:0] y,
                                           input logic ci);
      logic [3:0] g;
      logic [3:0] p;
      logic [3:0] c;
      g    = x & y;
      p    = x ^ y;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      return p ^ c;
   endfunction

   // (x + y) mod 3 for residues in 0..2
   function automatic logic [1:0] add3(input logic [1:0] x, input logic [1:0] y);
      logic [2:0] t;
      t = {1'b0, x} + {1'b0, y};
      if (t >= 3'd3) t = t - 3'd3;
      return t[1:0];
   endfunction

   // Residue mod 3: bit i weighs 2^i mod 3, i.e. 1 for even i and 2 for odd i
   function automatic logic [1:0] res3(input logic [WIDTH:0] x);
      logic [1:0] acc;
      acc = 2'd0;
      for (int unsigned i = 0; i <= WIDTH; i++) begin
         if (x[i]) acc = add3(acc, (i % 2 == 0) ? 2'd1 : 2'd2);
      end
      return acc;
   endfunction

   logic            adv;
   logic [HW-1:0]   lo_sum;
   logic            mid_c;
   logic [1:0]      pred;
   logic [HW-1:0]   hi_sum;
   logic            res_cout;
   logic [1:0]      act;
   logic            res_err;
   logic            count_evt;

   logic            s1_valid_d, s1_valid_q;
   logic [HW-1:0]   s1_lo_sum_d, s1_lo_sum_q;
   logic            s1_mid_c_d, s1_mid_c_q;
   logic [HW-1:0]   s1_a_hi_d, s1_a_hi_q;
   logic [HW-1:0]   s1_b_hi_d, s1_b_hi_q;
   logic            s1_fault_en_d, s1_fault_en_q;
   logic [SEL_W-1:0] s1_fault_sel_d, s1_fault_sel_q;
   logic [1:0]      s1_pred_d, s1_pred_q;
   logic            out_valid_d, out_valid_q;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic            cout_d, cout_q;
   logic            chk_err_d, chk_err_q;
   logic            err_flag_d, err_flag_q;
   logic [CNT_W-1:0] err_count_d, err_count_q;

   // Whole pipe moves together; bubbles are not squeezed out
   assign adv      = ~out_valid_q | out_ready;
   assign in_ready = adv;

   // Low-half adder with group carry chain, optional carry flip, residue prediction
   always_comb begin : s1_comb
      logic       carry;
      logic       ci;
      logic [1:0] gp;
      carry  = cin;
      ci     = 1'b0;
      gp     = 2'b00;
      lo_sum = '0;
      for (int unsigned g = 0; g < HG; g++) begin
         ci                = carry ^ (fault_en && (fault_sel == SEL_W'(g)));
         gp                = cla4_gp(a[4*g +: 4], b[4*g +: 4]);
         lo_sum[4*g +: 4]  = cla4_sum(a[4*g +: 4], b[4*g +: 4], ci);
         carry             = gp[1] | (gp[0] & ci);
      end
      mid_c = carry;
      // Prediction uses the fault-free operands so an injected flip shows up
      pred  = add3(add3(res3({1'b0, a}), res3({1'b0, b})), {1'b0, cin});
   end

   // Stage 1 register loads on advance
   always_comb begin
      s1_valid_d     = s1_valid_q;
      s1_lo_sum_d    = s1_lo_sum_q;
      s1_mid_c_d     = s1_mid_c_q;
      s1_a_hi_d      = s1_a_hi_q;
      s1_b_hi_d      = s1_b_hi_q;
      s1_fault_en_d  = s1_fault_en_q;
      s1_fault_sel_d = s1_fault_sel_q;
      s1_pred_d      = s1_pred_q;
      if (adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_lo_sum_d    = lo_sum;
            s1_mid_c_d     = mid_c;
            s1_a_hi_d      = a[WIDTH-1:HW];
            s1_b_hi_d      = b[WIDTH-1:HW];
            s1_fault_en_d  = fault_en;
            s1_fault_sel_d = fault_sel;
            s1_pred_d      = pred;
         end
      end
   end

   // High-half adder from the registered mid carry, then residue check
   always_comb begin : s2_comb
      logic       carry;
      logic       ci;
      logic [1:0] gp;
      carry  = s1_mid_c_q;
      ci     = 1'b0;
      gp     = 2'b00;
      hi_sum = '0;
      for (int unsigned g = 0; g < HG; g++) begin
         ci = carry ^ (s1_fault_en_q && (s1_fault_sel_q == SEL_W'(HG + g)));
         gp = cla4_gp(s1_a_hi_q[4*g +: 4], s1_b_hi_q[4*g +: 4]);
         hi_sum[4*g +: 4] = cla4_sum(s1_a_hi_q[4*g +: 4], s1_b_hi_q[4*g +: 4], ci);
         carry = gp[1] | (gp[0] & ci);
      end
      res_cout = carry;
      act      = res3({res_cout, hi_sum, s1_lo_sum_q});
      res_err  = (act != s1_pred_q);
   end

   // Output register loads on advance and holds while stalled
   always_comb begin
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      chk_err_d   = chk_err_q;
      if (adv) begin
         out_valid_d = s1_valid_q;
         chk_err_d   = s1_valid_q & res_err;
         if (s1_valid_q) begin
            sum_d  = {hi_sum, s1_lo_sum_q};
            cout_d = res_cout;
         end
      end
   end

   // Error bookkeeping: a counted error wins over a simultaneous clear
   assign count_evt = out_valid_q & out_ready & chk_err_q;
   always_comb begin
      err_flag_d  = err_flag_q;
      err_count_d = err_count_q;
      if (count_evt && err_clear) begin
         err_flag_d  = 1'b1;
         err_count_d = CNT_W'(1);
      end else if (count_evt) begin
         err_flag_d = 1'b1;
         if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + 1'b1;
      end else if (err_clear) begin
         err_flag_d  = 1'b0;
         err_count_d = '0;
      end
   end

   // State registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q     <= 1'b0;
         s1_lo_sum_q    <= '0;
         s1_mid_c_q     <= 1'b0;
         s1_a_hi_q      <= '0;
         s1_b_hi_q      <= '0;
         s1_fault_en_q  <= 1'b0;
         s1_fault_sel_q <= '0;
         s1_pred_q      <= 2'd0;
         out_valid_q    <= 1'b0;
         sum_q          <= '0;
         cout_q         <= 1'b0;
         chk_err_q      <= 1'b0;
         err_flag_q     <= 1'b0;
         err_count_q    <= '0;
      end else begin
         s1_valid_q     <= s1_valid_d;
         s1_lo_sum_q    <= s1_lo_sum_d;
         s1_mid_c_q     <= s1_mid_c_d;
         s1_a_hi_q      <= s1_a_hi_d;
         s1_b_hi_q      <= s1_b_hi_d;
         s1_fault_en_q  <= s1_fault_en_d;
         s1_fault_sel_q <= s1_fault_sel_d;
         s1_pred_q      <= s1_pred_d;
         out_valid_q    <= out_valid_d;
         sum_q          <= sum_d;
         cout_q         <= cout_d;
         chk_err_q      <= chk_err_d;
         err_flag_q     <= err_flag_d;
         err_count_q    <= err_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign chk_err   = chk_err_q;
   assign err_flag  = err_flag_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_abl17_cla_adder_pipe_chk.sv
// Bench for abl17_cla_adder_pipe_chk: a 32-bit instance for arithmetic, latency, stall
// and reset, and a 24-bit / 2-bit-counter instance for out-of-range select and saturation.
module tb_abl17_cla_adder_pipe_chk;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        err;
   } exp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic        m_in_valid, m_in_ready, m_cin, m_fault_en, m_out_valid, m_out_ready;
   logic [31:0] m_a, m_b, m_sum;
   logic [2:0]  m_fault_sel;
   logic        m_cout, m_chk_err, m_err_flag, m_err_clear;
   logic [7:0]  m_err_count;

   logic        s_in_valid, s_in_ready, s_cin, s_fault_en, s_out_valid, s_out_ready;
   logic [23:0] s_a, s_b, s_sum;
   logic [2:0]  s_fault_sel;
   logic        s_cout, s_chk_err, s_err_flag, s_err_clear;
   logic [1:0]  s_err_count;

   abl17_cla_adder_pipe_chk #(.WIDTH(32), .CNT_W(8)) u_main (
      .clock(clock), .reset_n(reset_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
      .a(m_a), .b(m_b), .cin(m_cin), .fault_en(m_fault_en), .fault_sel(m_fault_sel),
      .out_valid(m_out_valid), .out_ready(m_out_ready), .sum(m_sum), .cout(m_cout),
      .chk_err(m_chk_err), .err_flag(m_err_flag), .err_count(m_err_count),
      .err_clear(m_err_clear)
   );

   abl17_cla_adder_pipe_chk #(.WIDTH(24), .CNT_W(2)) u_small (
      .clock(clock), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b), .cin(s_cin), .fault_en(s_fault_en), .fault_sel(s_fault_sel),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout),
      .chk_err(s_chk_err), .err_flag(s_err_flag), .err_count(s_err_count),
      .err_clear(s_err_clear)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t m_q[$];
   exp_t s_q[$];
   int   m_cnt = 0, s_cnt = 0, m_pops = 0;
   bit   m_flg = 1'b0, s_flg = 1'b0;
   bit   m_acc, s_acc;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer add; a flipped carry into group sel moves the result by
   // -2^(4*sel) when that carry was 1 and +2^(4*sel) when it was 0.
   function automatic exp_t model(input int w, input longint unsigned x, input longint unsigned y,
                                  input bit ci, input bit fe, input int sel);
      longint unsigned full, m, c;
      exp_t e;
      full  = x + y + longint'(ci);
      e.err = 1'b0;
      if (fe && sel < w / 4) begin
         m = (64'd1 << (4 * sel)) - 64'd1;
         c = ((x & m) + (y & m) + longint'(ci)) >> (4 * sel);
         if (c != 0) full = full - (64'd1 << (4 * sel));
         else        full = full + (64'd1 << (4 * sel));
         e.err = 1'b1;
      end
      e.sum  = 32'(full & ((64'd1 << w) - 64'd1));
      e.cout = ((full >> w) & 64'd1) != 0;
      return e;
   endfunction

   function automatic logic [31:0] rand_op();
      case ($urandom_range(4))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h0;
         2:       return 32'h0000_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // One clock: inputs already driven after a falling edge; score handshakes, then
   // let the rising edge pass and compare error bookkeeping on the next falling edge.
   task automatic cycle();
      exp_t e;
      bit   m_evt, s_evt;
      #1;
      m_acc = 1'b0; s_acc = 1'b0; m_evt = 1'b0; s_evt = 1'b0;
      check_eq("m_in_ready", m_in_ready, !m_out_valid || m_out_ready);
      check_eq("s_in_ready", s_in_ready, !s_out_valid || s_out_ready);
      if (m_out_valid && m_out_ready) begin
         if (m_q.size() == 0) check_eq("m_extra_result", m_out_valid, 1'b0);
         else begin
            e = m_q.pop_front();
            check_eq("m_sum", m_sum, e.sum);
            check_eq("m_cout", m_cout, e.cout);
            check_eq("m_chk_err", m_chk_err, e.err);
            m_evt = e.err;
            m_pops++;
         end
      end
      if (m_in_valid && m_in_ready) begin
         m_q.push_back(model(32, m_a, m_b, m_cin, m_fault_en, int'(m_fault_sel)));
         m_acc = 1'b1;
      end
      if (s_out_valid && s_out_ready) begin
         if (s_q.size() == 0) check_eq("s_extra_result", s_out_valid, 1'b0);
         else begin
            e = s_q.pop_front();
            check_eq("s_sum", {8'h0, s_sum}, e.sum);
            check_eq("s_cout", s_cout, e.cout);
            check_eq("s_chk_err", s_chk_err, e.err);
            s_evt = e.err;
         end
      end
      if (s_in_valid && s_in_ready) begin
         s_q.push_back(model(24, {40'h0, s_a}, {40'h0, s_b}, s_cin, s_fault_en,
                             int'(s_fault_sel)));
         s_acc = 1'b1;
      end
      if (m_evt) begin
         m_flg = 1'b1;
         m_cnt = m_err_clear ? 1 : ((m_cnt < 255) ? m_cnt + 1 : m_cnt);
      end else if (m_err_clear) begin
         m_flg = 1'b0; m_cnt = 0;
      end
      if (s_evt) begin
         s_flg = 1'b1;
         s_cnt = s_err_clear ? 1 : ((s_cnt < 3) ? s_cnt + 1 : s_cnt);
      end else if (s_err_clear) begin
         s_flg = 1'b0; s_cnt = 0;
      end
      @(negedge clock);
      check_eq("m_err_count", m_err_count, m_cnt);
      check_eq("m_err_flag", m_err_flag, m_flg);
      check_eq("s_err_count", s_err_count, s_cnt);
      check_eq("s_err_flag", s_err_flag, s_flg);
   endtask

   task automatic m_send_chk(input logic [31:0] x, input logic [31:0] y, input logic ci,
                             input logic fe, input logic [2:0] sel, input logic [31:0] exp_sum,
                             input logic exp_cout, input logic exp_err);
      m_out_ready = 1'b1;
      m_a = x; m_b = y; m_cin = ci; m_fault_en = fe; m_fault_sel = sel; m_in_valid = 1'b1;
      cycle();
      check_eq("m_lat_accept", m_acc, 1'b1);
      m_in_valid = 1'b0; m_fault_en = 1'b0;
      check_eq("m_lat_k", m_out_valid, 1'b0);
      cycle();
      check_eq("m_lat_k1", m_out_valid, 1'b1);
      check_eq("m_lit_sum", m_sum, exp_sum);
      check_eq("m_lit_cout", m_cout, exp_cout);
      check_eq("m_lit_chk", m_chk_err, exp_err);
      cycle();
   endtask

   task automatic s_send_chk(input logic [23:0] x, input logic [23:0] y, input logic ci,
                             input logic fe, input logic [2:0] sel, input logic [23:0] exp_sum,
                             input logic exp_cout, input logic exp_err);
      s_out_ready = 1'b1;
      s_a = x; s_b = y; s_cin = ci; s_fault_en = fe; s_fault_sel = sel; s_in_valid = 1'b1;
      cycle();
      check_eq("s_lat_accept", s_acc, 1'b1);
      s_in_valid = 1'b0; s_fault_en = 1'b0;
      check_eq("s_lat_k", s_out_valid, 1'b0);
      cycle();
      check_eq("s_lat_k1", s_out_valid, 1'b1);
      check_eq("s_lit_sum", s_sum, exp_sum);
      check_eq("s_lit_cout", s_cout, exp_cout);
      check_eq("s_lit_chk", s_chk_err, exp_err);
      cycle();
   endtask

   task automatic m_stream(input int n, input int stall_pct);
      int sent = 0;
      int cyc  = 0;
      while ((sent < n || m_q.size() != 0) && cyc < 20 * n + 50) begin
         if (!m_in_valid && sent < n && $urandom_range(7) != 0) begin
            m_a = rand_op(); m_b = rand_op(); m_cin = 1'($urandom_range(1));
            m_fault_en = ($urandom_range(3) == 0); m_fault_sel = 3'($urandom_range(7));
            m_in_valid = 1'b1;
         end
         m_out_ready = ($urandom_range(99) >= stall_pct);
         m_err_clear = ($urandom_range(99) < 3);
         cycle();
         if (m_acc) begin
            sent++;
            m_in_valid = 1'b0;
         end
         cyc++;
      end
      m_in_valid = 1'b0; m_err_clear = 1'b0; m_out_ready = 1'b1;
      check_eq("m_stream_drain", m_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   idx, cyc, pops0;
      m_in_valid = 0; m_a = 0; m_b = 0; m_cin = 0; m_fault_en = 0; m_fault_sel = 0;
      m_out_ready = 1; m_err_clear = 0;
      s_in_valid = 0; s_a = 0; s_b = 0; s_cin = 0; s_fault_en = 0; s_fault_sel = 0;
      s_out_ready = 1; s_err_clear = 0;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check_eq("rst_out_valid", m_out_valid, 1'b0);
      check_eq("rst_sum", m_sum, 32'h0);
      check_eq("rst_cout", m_cout, 1'b0);
      check_eq("rst_chk_err", m_chk_err, 1'b0);
      check_eq("rst_err_flag", m_err_flag, 1'b0);
      check_eq("rst_err_count", m_err_count, 8'h0);
      check_eq("rst_in_ready", m_in_ready, 1'b1);
      check_eq("rst_s_out_valid", s_out_valid, 1'b0);
      reset_n = 1'b1;

      // Basic adds and carry ripple across both halves
      m_send_chk(32'h1, 32'h1, 1'b0, 1'b0, 3'd0, 32'h2, 1'b0, 1'b0);
      m_send_chk(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      m_send_chk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      // Flipped mid carry is caught and counted
      m_send_chk(32'h0000_FFFF, 32'h1, 1'b0, 1'b1, 3'd4, 32'h0, 1'b0, 1'b1);
      check_eq("t3_err_flag", m_err_flag, 1'b1);
      check_eq("t3_err_count", m_err_count, 8'd1);

      // Out-of-range select on the 6-group instance injects nothing
      s_send_chk(24'h00_FFFF, 24'h1, 1'b0, 1'b1, 3'd6, 24'h01_0000, 1'b0, 1'b0);
      s_send_chk(24'hFF_FFFF, 24'h1, 1'b0, 1'b1, 3'd7, 24'h00_0000, 1'b1, 1'b0);
      s_send_chk(24'h00_FFFF, 24'h1, 1'b0, 1'b1, 3'd3, 24'h00_F000, 1'b0, 1'b1);

      // Six back-to-back beats with a three-cycle output stall in the middle
      idx = 0; cyc = 0; pops0 = m_pops;
      while ((idx < 6 || m_q.size() != 0) && cyc < 60) begin
         m_out_ready = !(cyc >= 3 && cyc < 6);
         if (idx < 6) begin
            m_a = 32'h1111_1111 * idx + 32'h0F0F_0F0F; m_b = 32'h8000_0001 + idx;
            m_cin = idx[0]; m_in_valid = 1'b1;
         end else m_in_valid = 1'b0;
         cycle();
         if (m_acc) idx++;
         cyc++;
      end
      m_in_valid = 1'b0; m_out_ready = 1'b1;
      check_eq("t4_results", m_pops - pops0, 6);

      m_stream(300, 30);

      // Reset with two beats in flight
      m_out_ready = 1'b0;
      m_a = 32'h1234_5678; m_b = 32'h1; m_cin = 1'b0; m_in_valid = 1'b1;
      cycle();
      check_eq("t5_acc0", m_acc, 1'b1);
      m_a = 32'h0000_FFFF; m_fault_en = 1'b1; m_fault_sel = 3'd2;
      cycle();
      check_eq("t5_acc1", m_acc, 1'b1);
      m_in_valid = 1'b0; m_fault_en = 1'b0;
      check_eq("t5_full", m_out_valid, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("t5_out_valid", m_out_valid, 1'b0);
      check_eq("t5_err_count", m_err_count, 8'h0);
      check_eq("t5_err_flag", m_err_flag, 1'b0);
      m_q.delete(); s_q.delete();
      m_cnt = 0; m_flg = 1'b0; s_cnt = 0; s_flg = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      m_out_ready = 1'b1;
      repeat (4) begin
         cycle();
         check_eq("t5_stale", m_out_valid, 1'b0);
      end

      // Saturation of the 2-bit counter
      for (int i = 0; i < 5; i++) begin
         logic [23:0] x, y;
         logic [2:0]  sel;
         x = 24'($urandom); y = 24'($urandom); sel = 3'($urandom_range(5));
         e = model(24, {40'h0, x}, {40'h0, y}, 1'b0, 1'b1, int'(sel));
         s_send_chk(x, y, 1'b0, 1'b1, sel, e.sum[23:0], e.cout, e.err);
      end
      check_eq("t6_sat_count", s_err_count, 2'd3);
      check_eq("t6_sat_flag", s_err_flag, 1'b1);

      // Clear coincident with a counted error leaves one error recorded
      s_out_ready = 1'b0;
      s_a = 24'h00_0FFF; s_b = 24'h1; s_cin = 1'b0; s_fault_en = 1'b1; s_fault_sel = 3'd1;
      s_in_valid = 1'b1;
      cycle();
      check_eq("t6_acc", s_acc, 1'b1);
      s_in_valid = 1'b0; s_fault_en = 1'b0;
      for (int i = 0; i < 5 && !s_out_valid; i++) cycle();
      check_eq("t6_out_valid", s_out_valid, 1'b1);
      s_out_ready = 1'b1; s_err_clear = 1'b1;
      cycle();
      s_err_clear = 1'b0;
      check_eq("t6_clr_count", s_err_count, 2'd1);
      check_eq("t6_clr_flag", s_err_flag, 1'b1);
      s_err_clear = 1'b1;
      cycle();
      s_err_clear = 1'b0;
      check_eq("t6_clear_count", s_err_count, 2'd0);
      check_eq("t6_clear_flag", s_err_flag, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
